// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared constants, FSM encoding and GF(2^8) helpers for the AES-128 engine
package aes_pkg;
    localparam int AES_NR    = 10;
    localparam int AES_BLK_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } fsm_t;

    function automatic logic [7:0] rcon_of(input logic [3:0] rnd);
        case (rnd)
            4'd1:    rcon_of = 8'h01;
            4'd2:    rcon_of = 8'h02;
            4'd3:    rcon_of = 8'h04;
            4'd4:    rcon_of = 8'h08;
            4'd5:    rcon_of = 8'h10;
            4'd6:    rcon_of = 8'h20;
            4'd7:    rcon_of = 8'h40;
            4'd8:    rcon_of = 8'h80;
            4'd9:    rcon_of = 8'h1b;
            4'd10:   rcon_of = 8'h36;
            default: rcon_of = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

    // S-box as the affine map of the field inverse a^254, avoiding a 256-entry table.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        inv = 8'h01;
        sq  = a;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction
endpackage

// File: rtl/aes_add_round_key.sv
// rtl/aes_add_round_key.sv - round-key XOR
module aes_add_round_key (
    input  logic [127:0] i_state,
    input  logic [127:0] i_rkey,
    output logic [127:0] o_state
);
    assign o_state = i_state ^ i_rkey;
endmodule

// File: rtl/aes_key_step.sv
// rtl/aes_key_step.sv - one on-the-fly AES-128 key expansion step
module aes_key_step (
    input  logic [127:0] rkey,
    input  logic [7:0]   rcon,
    output logic [127:0] rk_next
);
    logic [31:0] w_rot, w_sub, w_temp, w_w0, w_w1, w_w2, w_w3;

    aes_rot_word u_rot (.i_word(rkey[31:0]), .o_word(w_rot));
    aes_sub_word u_sub (.i_word(w_rot),      .o_word(w_sub));

    assign w_temp  = w_sub ^ {rcon, 24'h0};
    assign w_w0    = rkey[127:96] ^ w_temp;
    assign w_w1    = rkey[95:64]  ^ w_w0;
    assign w_w2    = rkey[63:32]  ^ w_w1;
    assign w_w3    = rkey[31:0]   ^ w_w2;
    assign rk_next = {w_w0, w_w1, w_w2, w_w3};
endmodule

// File: rtl/aes_mix_columns.sv
// rtl/aes_mix_columns.sv - MixColumns over the four 32-bit columns
module aes_mix_columns
    import aes_pkg::*;
(
    input  logic [127:0] i_state,
    output logic [127:0] o_state
);
    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    always_comb begin
        o_state = '0;
        for (int c = 0; c < 4; c++) o_state[32*(3-c) +: 32] = mix_col(i_state[32*(3-c) +: 32]);
    end
endmodule

// File: rtl/aes_rot_word.sv
// rtl/aes_rot_word.sv - 32-bit word rotate left by one byte
module aes_rot_word (
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);
    assign o_word = {i_word[23:0], i_word[31:24]};
endmodule

// File: rtl/aes_shift_rows.sv
// rtl/aes_shift_rows.sv - row r rotated left by r columns; byte 0 at the MSB, column-major
module aes_shift_rows (
    input  logic [127:0] i_state,
    output logic [127:0] o_state
);
    always_comb begin
        o_state = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o_state[8*(15-(r+4*c)) +: 8] = i_state[8*(15-(r+4*((c+r)%4))) +: 8];
    end
endmodule

// File: rtl/aes_sub_bytes.sv
// rtl/aes_sub_bytes.sv - 128-bit byte substitution
module aes_sub_bytes
    import aes_pkg::*;
(
    input  logic [127:0] i_state,
    output logic [127:0] o_state
);
    always_comb begin
        o_state = '0;
        for (int i = 0; i < 16; i++) o_state[8*i +: 8] = sbox(i_state[8*i +: 8]);
    end
endmodule

// File: rtl/aes_sub_word.sv
// rtl/aes_sub_word.sv - 32-bit byte substitution
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);
    always_comb begin
        o_word = '0;
        for (int i = 0; i < 4; i++) o_word[8*i +: 8] = sbox(i_word[8*i +: 8]);
    end
endmodule

// File: rtl/aes128_enc_ctrl.sv
// rtl/aes128_enc_ctrl.sv - iterative one-round-per-clock AES-128 encryptor with valid/ready handshakes
module aes128_enc_ctrl
    import aes_pkg::*;
#(
    parameter int NR    = AES_NR,
    parameter int BLK_W = AES_BLK_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] plaintext,
    input  logic [BLK_W-1:0] key,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] ciphertext,
    output logic             busy
);
    if (NR != AES_NR || BLK_W != AES_BLK_W) begin : g_bad_cfg
        $error("aes128_enc_ctrl supports only NR=10 and BLK_W=128");
    end

    localparam logic [3:0] LAST_RND = 4'(NR);

    fsm_t             r_fsm;
    logic [BLK_W-1:0] r_state, r_rkey, r_ct;
    logic [3:0]       r_rnd;
    logic             r_out_valid, r_busy;
    logic [BLK_W-1:0] w_rk_next, w_sb, w_sr, w_mc, w_pre_ark, w_round_out;
    logic [7:0]       w_rcon;
    logic             w_accept;

    assign w_rcon = rcon_of(r_rnd);

    aes_key_step      u_key_step (.rkey(r_rkey), .rcon(w_rcon), .rk_next(w_rk_next));
    aes_sub_bytes     u_sub      (.i_state(r_state), .o_state(w_sb));
    aes_shift_rows    u_shift    (.i_state(w_sb),    .o_state(w_sr));
    aes_mix_columns   u_mix      (.i_state(w_sr),    .o_state(w_mc));
    aes_add_round_key u_ark      (.i_state(w_pre_ark), .i_rkey(w_rk_next), .o_state(w_round_out));

    // The final round bypasses MixColumns.
    assign w_pre_ark = (r_rnd == LAST_RND) ? w_sr : w_mc;

    assign in_ready   = rst_n & ((r_fsm == ST_IDLE) | ((r_fsm == ST_DONE) & out_ready));
    assign w_accept   = in_valid & in_ready;
    assign out_valid  = r_out_valid;
    assign ciphertext = r_ct;
    assign busy       = r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm       <= ST_IDLE;
            r_state     <= '0;
            r_rkey      <= '0;
            r_rnd       <= '0;
            r_ct        <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= plaintext ^ key;
                        r_rkey  <= key;
                        r_rnd   <= 4'd1;
                        r_fsm   <= ST_ROUND;
                        r_busy  <= 1'b1;
                    end
                end
                ST_ROUND: begin
                    if (abort || r_rnd == 4'd0 || r_rnd > LAST_RND) begin
                        r_fsm   <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_state <= '0;
                        r_rkey  <= '0;
                        r_rnd   <= '0;
                    end else begin
                        r_state <= w_round_out;
                        r_rkey  <= w_rk_next;
                        if (r_rnd == LAST_RND) begin
                            r_ct        <= w_round_out;
                            r_out_valid <= 1'b1;
                            r_fsm       <= ST_DONE;
                            r_busy      <= 1'b0;
                            r_rnd       <= '0;
                        end else begin
                            r_rnd <= r_rnd + 4'd1;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (in_valid) begin
                            r_state <= plaintext ^ key;
                            r_rkey  <= key;
                            r_rnd   <= 4'd1;
                            r_fsm   <= ST_ROUND;
                            r_busy  <= 1'b1;
                        end else begin
                            r_fsm <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_fsm       <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_rnd       <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aes128_enc_ctrl.sv
// tb/tb_aes128_enc_ctrl.sv - self-checking bench for aes128_enc_ctrl against a behavioural AES model
module tb_aes128_enc_ctrl;
    localparam logic [127:0] KB   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PB   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KC   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PC   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_Z = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         abort = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] plaintext = '0;
    logic [127:0] key = '0;
    logic         in_ready, out_valid, busy;
    logic [127:0] ciphertext;

    int n_tests = 0;
    int n_fail = 0;
    int n_edges = 0;
    int last_e0 = 0;
    int lat;

    logic [7:0]   sb [256];
    int           m_left = 0;
    logic         m_ov = 1'b0;
    logic         m_acc;
    logic [127:0] m_ct = '0;
    logic [127:0] m_pend = '0;

    aes128_enc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .plaintext(plaintext), .key(key), .abort(abort), .out_valid(out_valid),
        .out_ready(out_ready), .ciphertext(ciphertext), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] dbl(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = (b << n) | (b >> (8 - n));
        return r;
    endfunction

    // Classic generator walk: p steps by x3, q by its inverse, so q = 1/p.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [127:0] aes_model(input logic [127:0] k, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
                rc = dbl(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (rd < 10) begin
                    s[4*c]   = dbl(a0) ^ dbl(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ dbl(a1) ^ dbl(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ dbl(a2) ^ dbl(a3) ^ a3;
                    s[4*c+3] = dbl(a0) ^ a0 ^ a1 ^ a2 ^ dbl(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
                for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[4*rd+c][31-8*r -: 8];
            end
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic exp_in_ready();
        return rst_n && ((m_left == 0 && !m_ov) || (m_ov && out_ready));
    endfunction

    // Timeline model: a block takes 10 edges, then waits for out_ready.
    initial begin : model
        forever begin
            @(posedge clk);
            n_edges++;
            if (!rst_n) begin
                m_left = 0;
                m_ov   = 1'b0;
                m_ct   = '0;
            end else begin
                m_acc = in_valid && exp_in_ready();
                if (m_left > 0) begin
                    if (abort) begin
                        m_left = 0;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin
                            m_ov = 1'b1;
                            m_ct = m_pend;
                        end
                    end
                end else if (m_ov && out_ready) begin
                    m_ov = 1'b0;
                end
                if (m_acc) begin
                    m_pend = aes_model(key, plaintext);
                    m_left = 10;
                end
            end
            #1;
            check("cyc_in_ready", in_ready, exp_in_ready());
            check("cyc_out_valid", out_valid, m_ov);
            check("cyc_busy", busy, m_left > 0);
            check("cyc_ciphertext", ciphertext, m_ct);
        end
    end

    task automatic send(input logic [127:0] k, input logic [127:0] p);
        @(negedge clk);
        key = k; plaintext = p; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        last_e0 = n_edges;
    endtask

    task automatic wait_ov(output int l);
        l = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                l = n_edges - last_e0;
                break;
            end
        end
    endtask

    initial begin : timeout
        #200000;
        $display("FAIL timeout: summary not reached, required finish within 200000 time units");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        build_sbox();
        check("model_B", aes_model(KB, PB), CT_B);
        check("model_C1", aes_model(KC, PC), CT_C);
        check("model_zero", aes_model('0, '0), CT_Z);

        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ct", ciphertext, '0);
        rst_n = 1'b1;
        #1 check("rst_in_ready", in_ready, 1'b1);

        send(KB, PB);
        repeat (2) @(negedge clk);
        key = ~KB; plaintext = ~PB; in_valid = 1'b1;
        #1 check("busy_in_ready", in_ready, 1'b0);
        check("busy_flag", busy, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_ov(lat);
        check("B_latency", lat, 10);
        check("B_ct", ciphertext, CT_B);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_ct", ciphertext, CT_B);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_out_valid", out_valid, 1'b1);
        end

        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; key = KC; plaintext = PC;
        #1 check("b2b_in_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        last_e0 = n_edges;
        check("b2b_ov_drop", out_valid, 1'b0);
        wait_ov(lat);
        check("C1_latency", lat, 10);
        check("C1_ct", ciphertext, CT_C);

        send('0, '0);
        wait_ov(lat);
        check("zero_ct", ciphertext, CT_Z);

        send(KB, PB);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1 check("abort_busy", busy, 1'b0);
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_out_valid", out_valid, 1'b0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("abort_no_out", out_valid, 1'b0);
        end
        send(KB, PB);
        wait_ov(lat);
        check("after_abort_ct", ciphertext, CT_B);

        send(KC, PC);
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_ct", ciphertext, '0);
        check("mid_rst_busy", busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send(KC, PC);
        wait_ov(lat);
        check("after_rst_latency", lat, 10);
        check("after_rst_ct", ciphertext, CT_C);

        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            in_valid  = 1'($urandom % 2);
            out_ready = (($urandom % 4) != 0);
            abort     = (($urandom % 40) == 0);
            key       = {$urandom, $urandom, $urandom, $urandom};
            plaintext = {$urandom, $urandom, $urandom, $urandom};
        end
        @(negedge clk);
        in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
        repeat (15) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
